aes_pkt_sequencer: RTL and testbench
====================================

Name: aes_pkt_sequencer

Overview:
- Upstream stage of the 64-bit AES FIFO core. It accepts {data, key} packets over a valid/ready handshake and buffers them.
- It replays each packet into the core as a one-cycle aes_we pulse with data and key stable for setup (encryption phase).
- On request, it replays the same packets in the same order as aes_re pulses (decryption phase).
- Alongside each decryption it drives the original plaintext and a check strobe for the scoreboard.

Parameters:
- DEPTH, 16, packet buffer entries; must equal the AES core's internal FIFO depth.
- PW, 64, data and key width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream packet valid.
- in_ready  out  1  sequencer can accept a packet.
- in_data  in  PW  plaintext.
- in_key  in  PW  per-packet key.
- start_dec  in  1  single-cycle request to begin the decryption phase.
- aes_data  out  PW  data to the AES core `data` input.
- aes_key  out  PW  key to the AES core `key` input.
- aes_we  out  1  AES encrypt/write strobe.
- aes_re  out  1  AES decrypt/read strobe.
- exp_data  out  PW  expected plaintext for the scoreboard.
- sb_strobe  out  1  scoreboard sample strobe.
- pkt_count  out  $clog2(DEPTH)+1  packets accepted in the current batch.
- busy  out  1  state is not IDLE, or dec_pending is set.
- done  out  1  one-cycle pulse at the end of the decryption phase.

Behaviour:
- Reset:
  - Every output is 0, except in_ready, which is 1 from the first cycle after reset.
  - wr_ptr, enc_ptr, dec_ptr and dec_pending are cleared; state is IDLE.
  - Buffer contents are don't-care.
  - Reset mid-operation aborts immediately. No aes_we or aes_re is issued in the cycle after rst is sampled high.
- Accept rule:
  - in_ready = !dec_pending && state not in {DEC_SETUP, DEC_RE, DEC_CHK, DONE} && wr_ptr < DEPTH.
  - A transfer occurs on in_valid && in_ready: mem[wr_ptr] <= {in_data, in_key}, then wr_ptr++.
- start_dec:
  - Sets dec_pending when wr_ptr > 0, or when a transfer occurs in the same cycle.
  - Ignored when the batch is empty, when dec_pending is already set, or when in a DEC state or DONE.
  - If start_dec and a transfer occur in the same cycle, the packet is accepted and encrypted before decryption starts.
- FSM:
  - IDLE: go to ENC_SETUP if enc_ptr < wr_ptr. Otherwise go to DEC_SETUP if dec_pending. Otherwise stay. aes_data and aes_key are 0.
  - ENC_SETUP: aes_data and aes_key = mem[enc_ptr]; aes_we = 0; go to ENC_WE.
  - ENC_WE: same aes_data and aes_key; aes_we = 1; enc_ptr++; go to IDLE.
    - Each packet occupies 3 cycles minimum: ENC_SETUP, ENC_WE, IDLE.
  - DEC_SETUP: clear dec_pending on entry. aes_data, aes_key and exp_data = mem[dec_ptr]; go to DEC_RE.
  - DEC_RE: same values; aes_re = 1; go to DEC_CHK.
  - DEC_CHK: same values held; sb_strobe = 1; dec_ptr++. If dec_ptr+1 == wr_ptr, go to DONE; else go to DEC_SETUP.
  - DONE: done = 1; wr_ptr, enc_ptr and dec_ptr are cleared; go to IDLE with a new empty batch.
- Invariants:
  - aes_we and aes_re are never both high.
  - At most DEPTH aes_we pulses occur per batch.
  - The number of aes_re pulses equals the number of aes_we pulses in a batch.
  - Pointers never wrap; the full condition is wr_ptr == DEPTH.
- in_valid while in_ready is 0: the upstream source must hold in_data and in_key stable; no transfer occurs.

Decomposition:
- aes_pkg holds:
  - the PW and DEPTH defaults;
  - the state enum (IDLE, ENC_SETUP, ENC_WE, DEC_SETUP, DEC_RE, DEC_CHK, DONE);
  - the packet struct {data, key}.
- One sub-module, aes_pkt_buf: a DEPTH x 2PW register array with one write port and one combinational read port.

Test Plan:
- Single packet:
  - Stimulus: data 0x0123456789ABCDEF, key 0x133457799BBCDFF1, then start_dec.
  - aes_we pulses once, with both values stable in the preceding ENC_SETUP cycle.
  - aes_re pulses once, then sb_strobe follows with exp_data 0x0123456789ABCDEF; done pulses; pkt_count returns to 0.
- Fill:
  - Stimulus: 16 back-to-back packets, data i and key ~i.
  - in_ready drops after the 16th transfer; a 17th in_valid is not accepted.
  - 16 aes_we pulses occur, in order.
- Simultaneous events: start_dec in the same cycle as the 3rd transfer -> all 3 aes_we pulses precede the first aes_re; exactly 3 aes_re and 3 sb_strobe pulses.
- Empty start: start_dec with pkt_count == 0 -> no state change; busy stays 0; no done pulse.
- Reset mid-decryption:
  - Stimulus: rst asserted during DEC_RE of packet 2 of 4.
  - Next cycle: all outputs 0, in_ready 1, pkt_count 0.
  - A new 1-packet batch then completes normally.
- Backpressure: in_valid held with data 0xDEADBEEF00000001 during the decryption phase -> no transfer until after done; accepted as entry 0 of the new batch.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared defaults, FSM state encoding and packet layout for the AES packet sequencer.
package aes_pkg;

   localparam int PW_DEFAULT    = 64;
   localparam int DEPTH_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE,
      ENC_SETUP,
      ENC_WE,
      DEC_SETUP,
      DEC_RE,
      DEC_CHK,
      DONE
   } state_t;

   typedef struct packed {
      logic [PW_DEFAULT-1:0] data;
      logic [PW_DEFAULT-1:0] key;
   } pkt_t;

endpackage

// File: rtl/aes_pkt_buf.sv
// Packet buffer: DEPTH entries of {data, key}, one synchronous write port and
// one combinational read port. Contents are not reset.
module aes_pkt_buf
   import aes_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int W     = 2 * PW_DEFAULT
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/aes_pkt_sequencer.sv
// Buffers {data, key} packets, replays them into the AES core as write pulses,
// then on request replays the same batch as read pulses with scoreboard strobes.
module aes_pkt_sequencer
   import aes_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int PW    = PW_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PW-1:0]          in_data,
   input  logic [PW-1:0]          in_key,
   input  logic                   start_dec,
   output logic [PW-1:0]          aes_data,
   output logic [PW-1:0]          aes_key,
   output logic                   aes_we,
   output logic                   aes_re,
   output logic [PW-1:0]          exp_data,
   output logic                   sb_strobe,
   output logic [$clog2(DEPTH):0] pkt_count,
   output logic                   busy,
   output logic                   done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   wr_ptr;
   logic [CW-1:0]   enc_ptr;
   logic [CW-1:0]   dec_ptr;
   logic            dec_pending;
   logic            dec_locked;
   logic            dec_read;
   logic            xfer;
   logic            dec_req;
   logic [AW-1:0]   rd_addr;
   logic [2*PW-1:0] rd_pkt;
   logic [PW-1:0]   rd_data;
   logic [PW-1:0]   rd_key;

   assign dec_locked = (state == DEC_SETUP) || (state == DEC_RE) ||
                       (state == DEC_CHK)   || (state == DONE);
   assign dec_read   = (state == DEC_SETUP) || (state == DEC_RE) || (state == DEC_CHK);

   assign in_ready  = !dec_pending && !dec_locked && (wr_ptr < CW'(DEPTH));
   assign xfer      = in_valid && in_ready;
   // A start request in the same cycle as the first transfer still counts.
   assign dec_req   = start_dec && !dec_pending && !dec_locked &&
                      ((wr_ptr != '0) || xfer);

   assign pkt_count = wr_ptr;
   assign busy      = (state != IDLE) || dec_pending;

   assign rd_addr = dec_read ? dec_ptr[AW-1:0] : enc_ptr[AW-1:0];
   assign rd_data = rd_pkt[2*PW-1:PW];
   assign rd_key  = rd_pkt[PW-1:0];

   aes_pkt_buf #(
      .DEPTH (DEPTH),
      .W     (2 * PW)
   ) u_buf (
      .clk   (clk),
      .we    (xfer),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({in_data, in_key}),
      .raddr (rd_addr),
      .rdata (rd_pkt)
   );

   // State and pointer registers; DONE empties the batch for the next round.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         enc_ptr     <= '0;
         dec_ptr     <= '0;
         dec_pending <= 1'b0;
      end else begin
         state <= state_next;
         if (state == DONE) begin
            wr_ptr  <= '0;
            enc_ptr <= '0;
            dec_ptr <= '0;
         end else begin
            if (xfer) begin
               wr_ptr <= wr_ptr + CW'(1);
            end
            if (state == ENC_WE) begin
               enc_ptr <= enc_ptr + CW'(1);
            end
            if (state == DEC_CHK) begin
               dec_ptr <= dec_ptr + CW'(1);
            end
         end
         if (state_next == DEC_SETUP) begin
            dec_pending <= 1'b0;
         end else if (dec_req) begin
            dec_pending <= 1'b1;
         end
      end
   end

   // Next-state and core-facing outputs; encryption always drains before decryption.
   always_comb begin
      state_next = state;
      aes_data   = '0;
      aes_key    = '0;
      aes_we     = 1'b0;
      aes_re     = 1'b0;
      exp_data   = '0;
      sb_strobe  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (enc_ptr < wr_ptr) begin
               state_next = ENC_SETUP;
            end else if (dec_pending) begin
               state_next = DEC_SETUP;
            end
         end
         ENC_SETUP: begin
            aes_data   = rd_data;
            aes_key    = rd_key;
            state_next = ENC_WE;
         end
         ENC_WE: begin
            aes_data   = rd_data;
            aes_key    = rd_key;
            aes_we     = 1'b1;
            state_next = IDLE;
         end
         DEC_SETUP: begin
            aes_data   = rd_data;
            aes_key    = rd_key;
            exp_data   = rd_data;
            state_next = DEC_RE;
         end
         DEC_RE: begin
            aes_data   = rd_data;
            aes_key    = rd_key;
            exp_data   = rd_data;
            aes_re     = 1'b1;
            state_next = DEC_CHK;
         end
         DEC_CHK: begin
            aes_data  = rd_data;
            aes_key   = rd_key;
            exp_data  = rd_data;
            sb_strobe = 1'b1;
            if ((dec_ptr + CW'(1)) == wr_ptr) begin
               state_next = DONE;
            end else begin
               state_next = DEC_SETUP;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_pkt_sequencer.sv
// Scoreboard bench for aes_pkt_sequencer: accepted packets queue their expected
// write, read and check responses; a monitor pops them as the DUT pulses.
module tb_aes_pkt_sequencer;
   import aes_pkg::*;

   localparam int PW    = 64;
   localparam int DEPTH = 16;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          in_valid  = 1'b0;
   logic          start_dec = 1'b0;
   logic [PW-1:0] in_data   = '0;
   logic [PW-1:0] in_key    = '0;
   logic          in_ready;
   logic [PW-1:0] aes_data;
   logic [PW-1:0] aes_key;
   logic          aes_we;
   logic          aes_re;
   logic [PW-1:0] exp_data;
   logic          sb_strobe;
   logic [4:0]    pkt_count;
   logic          busy;
   logic          done;

   int checks   = 0;
   int errors   = 0;
   int got_we   = 0;
   int got_re   = 0;
   int got_sb   = 0;
   int got_done = 0;

   pkt_t          we_q[$];
   pkt_t          re_q[$];
   logic [PW-1:0] sb_q[$];

   aes_pkt_sequencer #(.DEPTH(DEPTH), .PW(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .start_dec (start_dec),
      .aes_data  (aes_data),
      .aes_key   (aes_key),
      .aes_we    (aes_we),
      .aes_re    (aes_re),
      .exp_data  (exp_data),
      .sb_strobe (sb_strobe),
      .pkt_count (pkt_count),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
      end
   endtask

   task automatic reportUnexpected(input string what);
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_%s: actual pulse, required no pending expectation", what);
   endtask

   // Drives one packet, waiting (bounded) for in_ready, and queues its responses.
   task automatic applyStimulus(input logic [63:0] d, input logic [63:0] k,
                                input logic with_start);
      int   waited   = 0;
      logic accepted = 1'b0;
      in_data = d;
      in_key  = k;
      while (!accepted && waited < 400) begin
         @(negedge clk);
         in_valid = 1'b1;
         if (in_ready) begin
            start_dec = with_start;
            @(posedge clk);
            #1;
            accepted = 1'b1;
         end else begin
            waited++;
         end
      end
      in_valid  = 1'b0;
      start_dec = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: actual no transfer, required transfer of %0h", d);
      end else begin
         we_q.push_back(pkt_t'({d, k}));
         re_q.push_back(pkt_t'({d, k}));
         sb_q.push_back(d);
      end
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start_dec = 1'b1;
      @(posedge clk);
      #1;
      start_dec = 1'b0;
   endtask

   task automatic waitDone(input string name, input int base);
      int n = 0;
      while (got_done == base && n < 600) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput(name, 64'(got_done - base), 64'd1);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_aes_data"}, aes_data, 64'd0);
      checkOutput({tag, "_aes_key"}, aes_key, 64'd0);
      checkOutput({tag, "_exp_data"}, exp_data, 64'd0);
      checkOutput({tag, "_strobes"}, 64'({aes_we, aes_re, sb_strobe, done, busy}), 64'd0);
      checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      checkOutput({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a strobe.
   initial begin : monitor
      pkt_t          e;
      logic [PW-1:0] prev_data = '0;
      logic [PW-1:0] prev_key  = '0;
      logic          prev_we   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (aes_we || aes_re) begin
               checkOutput("we_re_exclusive", 64'(aes_we & aes_re), 64'd0);
            end
            if (aes_we) begin
               got_we++;
               if (we_q.size() == 0) begin
                  reportUnexpected("aes_we");
               end else begin
                  e = we_q.pop_front();
                  checkOutput("we_data", aes_data, e.data);
                  checkOutput("we_key", aes_key, e.key);
                  checkOutput("we_setup_data", prev_data, e.data);
                  checkOutput("we_setup_key", prev_key, e.key);
                  checkOutput("we_setup_no_pulse", 64'(prev_we), 64'd0);
               end
            end
            if (aes_re) begin
               got_re++;
               checkOutput("we_before_re", 64'(we_q.size()), 64'd0);
               if (re_q.size() == 0) begin
                  reportUnexpected("aes_re");
               end else begin
                  e = re_q.pop_front();
                  checkOutput("re_data", aes_data, e.data);
                  checkOutput("re_key", aes_key, e.key);
               end
            end
            if (sb_strobe) begin
               got_sb++;
               if (sb_q.size() == 0) begin
                  reportUnexpected("sb_strobe");
               end else begin
                  checkOutput("sb_exp_data", exp_data, sb_q.pop_front());
               end
            end
            if (done) begin
               got_done++;
            end
         end
         prev_data = aes_data;
         prev_key  = aes_key;
         prev_we   = aes_we;
      end
   end

   initial begin : watchdog
      #300000;
      $display("[TB] FAIL watchdog: actual simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int base_done;
      int base_re;
      int base_sb;
      int n;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetState("reset");

      $display("[TB] single packet");
      applyStimulus(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
      checkOutput("single_pkt_count", 64'(pkt_count), 64'd1);
      base_done = got_done;
      pulseStart();
      waitDone("single_done", base_done);
      @(negedge clk);
      checkOutput("single_pkt_count_cleared", 64'(pkt_count), 64'd0);
      checkOutput("single_busy_cleared", 64'(busy), 64'd0);

      $display("[TB] empty start");
      base_done = got_done;
      pulseStart();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("empty_busy", 64'(busy), 64'd0);
      end
      checkOutput("empty_no_done", 64'(got_done - base_done), 64'd0);
      checkOutput("empty_pkt_count", 64'(pkt_count), 64'd0);

      $display("[TB] fill");
      base_re = got_re;
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(64'(i), ~64'(i), 1'b0);
      end
      @(negedge clk);
      checkOutput("fill_in_ready_low", 64'(in_ready), 64'd0);
      in_data  = 64'hFFFF0000FFFF0000;
      in_key   = 64'h1;
      in_valid = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("fill_17th_rejected", 64'(pkt_count), 64'd16);
      in_valid = 1'b0;
      base_done = got_done;
      pulseStart();
      waitDone("fill_done", base_done);
      checkOutput("fill_re_count", 64'(got_re - base_re), 64'd16);

      $display("[TB] simultaneous start and transfer");
      base_re   = got_re;
      base_sb   = got_sb;
      base_done = got_done;
      applyStimulus(64'hA5A5A5A500000001, 64'h1111111111111111, 1'b0);
      applyStimulus(64'hA5A5A5A500000002, 64'h2222222222222222, 1'b0);
      applyStimulus(64'hA5A5A5A500000003, 64'h3333333333333333, 1'b1);
      waitDone("simul_done", base_done);
      checkOutput("simul_re_count", 64'(got_re - base_re), 64'd3);
      checkOutput("simul_sb_count", 64'(got_sb - base_sb), 64'd3);

      $display("[TB] reset mid-decryption");
      base_re   = got_re;
      base_done = got_done;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(64'hC0DE000000000000 | 64'(i), 64'h5A5A5A5A5A5A5A5A ^ 64'(i),
                       (i == 3) ? 1'b1 : 1'b0);
      end
      n = 0;
      while (got_re < base_re + 2 && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("midrst_reached_re2", 64'(got_re - base_re), 64'd2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      we_q.delete();
      re_q.delete();
      sb_q.delete();
      @(negedge clk);
      checkResetState("midrst");
      checkOutput("midrst_no_done", 64'(got_done - base_done), 64'd0);
      applyStimulus(64'h0BADF00D0BADF00D, 64'h7777777777777777, 1'b0);
      base_done = got_done;
      pulseStart();
      waitDone("midrst_new_batch_done", base_done);

      $display("[TB] backpressure during decryption");
      applyStimulus(64'h1234000000000001, 64'h9999999999999999, 1'b0);
      applyStimulus(64'h1234000000000002, 64'h8888888888888888, 1'b1);
      base_done = got_done;
      applyStimulus(64'hDEADBEEF00000001, 64'h0F0F0F0F0F0F0F0F, 1'b0);
      checkOutput("bp_accept_after_done", 64'(got_done - base_done), 64'd1);
      checkOutput("bp_entry0_pkt_count", 64'(pkt_count), 64'd1);
      base_done = got_done;
      pulseStart();
      waitDone("bp_done", base_done);

      repeat (3) @(negedge clk);
      checkOutput("final_we_q_empty", 64'(we_q.size()), 64'd0);
      checkOutput("final_re_q_empty", 64'(re_q.size()), 64'd0);
      checkOutput("final_sb_q_empty", 64'(sb_q.size()), 64'd0);
      checkOutput("final_we_re_balance", 64'(got_we - got_re), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
